// File: rtl/pwf_ctrl_if.sv
// Event channel from pwf_ctrl to its downstream consumer: a width/verdict
// record transferred with a valid/ready handshake.
`timescale 1ns/1ps
interface pwf_ctrl_if #(
  parameter int CNT_W = 8
);
  logic             evt_valid;
  logic             evt_ready;
  logic [CNT_W-1:0] evt_width;
  logic             evt_ok;

  modport master (output evt_valid, output evt_width, output evt_ok, input evt_ready);
  modport slave  (input evt_valid, input evt_width, input evt_ok, output evt_ready);
endinterface

// File: rtl/pwf_ctrl.sv
// Pulse-width filter and measurement controller: synchronizes `a`, qualifies
// pulses against min_r, drives `c`, reports width/verdict. Option macro: PWF_CTRL_TIMEOUT_EN.
`timescale 1ns/1ps
module pwf_ctrl #(
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk4m,
  input  logic             rst,
  input  logic             a,
  input  logic             cfg_we,
  input  logic [CNT_W-1:0] cfg_min,
  input  logic [CNT_W-1:0] cfg_max,
  output logic             c,
  output logic             busy,
  output logic             ovf,
  pwf_ctrl_if.master       evt
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_MEAS     = 2'd1;
  localparam logic [1:0] S_REPORT   = 2'd2;
  localparam logic [1:0] S_WAIT_LOW = 2'd3;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam int unsigned      MAX_INT = (CNT_W >= 31) ? 32'h7FFF_FFFF : ((32'd1 << CNT_W) - 32'd1);
  // Default window clamped so narrow counters still get a representable value.
  localparam logic [CNT_W-1:0] MIN_RST = CNT_W'((MAX_INT < 32'd10) ? MAX_INT : 32'd10);
  localparam logic [CNT_W-1:0] MAX_RST = CNT_W'((MAX_INT < 32'd16) ? MAX_INT : 32'd16);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [SYNC_STAGES-1:0] vld_q, vld_d;
  logic                   a_s;
  logic                   a_s_dly_q, a_s_dly_d;
  logic                   rise;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] min_eff;
  logic [CNT_W-1:0] min_q, min_d;
  logic [CNT_W-1:0] max_q, max_d;
  logic [CNT_W-1:0] width_q, width_d;
  logic             ok_q, ok_d;
  logic             c_q, c_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             ovf_q, ovf_d;

  // vld tracks which synchronizer stages hold a real post-reset sample.
  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        assign sync_d[gi] = a;
        assign vld_d[gi]  = 1'b1;
      end else begin : g_next
        assign sync_d[gi] = sync_q[gi-1];
        assign vld_d[gi]  = vld_q[gi-1];
      end
    end
  endgenerate

  assign a_s = sync_q[SYNC_STAGES-1];

  // The delayed copy idles high until the chain is refilled, so a level that
  // was already high across reset is not taken for a new rising edge.
  assign a_s_dly_d = vld_q[SYNC_STAGES-1] ? a_s : 1'b1;
  assign rise      = a_s & ~a_s_dly_q;

  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + CNT_ONE);
  assign min_eff = (min_q == '0) ? CNT_ONE : min_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    min_d   = min_q;
    max_d   = max_q;
    width_d = width_q;
    ok_d    = ok_q;
    c_d     = c_q;
    ovf_d   = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (cfg_we) begin
          min_d = cfg_min;
          max_d = cfg_max;
          ovf_d = 1'b0;
        end
        if (rise) begin
          state_d = S_MEAS;
          cnt_d   = CNT_ONE;
          c_d     = (CNT_ONE >= min_eff);
        end
      end

      S_MEAS: begin
        if (!a_s) begin
          state_d = S_REPORT;
          width_d = cnt_q;
          ok_d    = (min_q <= cnt_q) && (cnt_q <= max_q);
          c_d     = 1'b0;
        end
`ifdef PWF_CTRL_TIMEOUT_EN
        else if (cnt_q == CNT_MAX) begin
          state_d = S_REPORT;
          width_d = CNT_MAX;
          ok_d    = 1'b0;
          c_d     = 1'b0;
        end
`endif
        else begin
          cnt_d = cnt_inc;
          if (cnt_inc >= min_eff) begin
            c_d = 1'b1;
          end
        end
      end

      S_REPORT: begin
        if (rise) begin
          ovf_d = 1'b1;
        end
        if (valid_q && evt.evt_ready) begin
          state_d = a_s ? S_WAIT_LOW : S_IDLE;
        end
      end

      S_WAIT_LOW: begin
        c_d = 1'b0;
        if (!a_s) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        c_d     = 1'b0;
      end
    endcase
  end

  assign valid_d = (state_d == S_REPORT);
  assign busy_d  = (state_d != S_IDLE);

  always_ff @(posedge clk4m) begin
    if (rst) begin
      sync_q    <= '0;
      vld_q     <= '0;
      a_s_dly_q <= 1'b1;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      min_q     <= MIN_RST;
      max_q     <= MAX_RST;
      width_q   <= '0;
      ok_q      <= 1'b0;
      c_q       <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      vld_q     <= vld_d;
      a_s_dly_q <= a_s_dly_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      min_q     <= min_d;
      max_q     <= max_d;
      width_q   <= width_d;
      ok_q      <= ok_d;
      c_q       <= c_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      ovf_q     <= ovf_d;
    end
  end

  assign c             = c_q;
  assign busy          = busy_q;
  assign ovf           = ovf_q;
  assign evt.evt_valid = valid_q;
  assign evt.evt_width = width_q;
  assign evt.evt_ok    = ok_q;

endmodule

// File: doc/pwf_ctrl.md
# pwf_ctrl

Controller that sequences pulse-width filtering and measurement on a single asynchronous input in the 4 MHz domain. It synchronizes the raw input, qualifies pulses against a programmable minimum width, and drives the filtered output `c`. It reports each completed pulse's width and window verdict to a downstream consumer over a valid/ready handshake. It sits between the raw pulse source and the event-processing logic that previously took the filter output directly.

## Interface
- `CNT_W`, 8: width counter / config width.
- `SYNC_STAGES`, 2: input synchronizer depth (>=2).
- `clk4m`  in  1  system clock, 4 MHz.
- `rst`  in  1  synchronous, active-high reset.
- `a`  in  1  raw asynchronous pulse input.
- `cfg_we`  in  1  load `cfg_min`/`cfg_max`; clears `ovf`.
- `cfg_min`  in  CNT_W  minimum qualifying width, in cycles.
- `cfg_max`  in  CNT_W  maximum accepted width, in cycles.
- `c`  out  1  filtered output.
- `evt_valid`  out  1  pulse event available.
- `evt_ready`  in  1  consumer accepts event.
- `evt_width`  out  CNT_W  measured high time, in cycles.
- `evt_ok`  out  1  `cfg_min <= evt_width <= cfg_max`.
- `busy`  out  1  FSM not in IDLE.
- `ovf`  out  1  sticky flag: pulse dropped while an event was pending.

## Operation
- Reset values: `c=0`, `evt_valid=0`, `evt_width=0`, `evt_ok=0`, `busy=0`, `ovf=0`; `min_r=10`, `max_r=16`; state IDLE; synchronizer flops cleared.
- `a` passes through SYNC_STAGES flops to produce `a_s`. A registered `a_s_d` provides edge detection.
- IDLE: on a rising `a_s` (`a_s & ~a_s_d`), go to MEAS with `cnt=1`.
- MEAS: while `a_s=1`, `cnt` increments and saturates at 2^CNT_W-1. `c` is set on the edge where the next `cnt` value is >= `min_eff`, where `min_eff = max(min_r,1)`. On `a_s=0`, go to REPORT: latch `evt_width=cnt`, compute `evt_ok`, set `c=0`.
- REPORT: `evt_valid=1`; `evt_width` and `evt_ok` are held stable. On `evt_valid & evt_ready`, go to IDLE, or to WAIT_LOW if `a_s=1`. A rising `a_s` while in REPORT drops that pulse and sets `ovf=1`.
- WAIT_LOW: `c=0`; return to IDLE when `a_s=0`. A dropped pulse here does not set `ovf`.
- `cfg_we` takes effect only in IDLE and is ignored in every other state. It loads `min_r`/`max_r` and clears `ovf` on the same edge.
- If `min_r > max_r`, `evt_ok` is always 0.
- All compares are unsigned, CNT_W bits wide.
- Reset asserted in any state returns everything to reset values on the next edge. A pending event is discarded.

## Timing
- Let e0 be the first edge that samples `a=1`.
  - `c` rises at edge e0 + SYNC_STAGES + min_eff − 1.
  - A pulse sampled high for W edges gives `c` high for W − min_eff + 1 cycles when W >= min_eff; otherwise `c` never rises.
- Let f0 be the first edge that samples `a=0`.
  - `c` falls and `evt_valid` rises at edge f0 + SYNC_STAGES.
- `evt_width` equals W, the number of edges that sampled `a=1`, saturated at 2^CNT_W−1.
- Handshake:
  - `evt_valid` falls on the edge after `evt_ready` is sampled high.
  - With `evt_ready` tied high, `evt_valid` is a one-cycle pulse.
  - The minimum low gap between reported pulses is 1 cycle (REPORT→IDLE).
- `busy` is registered and equals state != IDLE.

## Configuration
- Macro `PWF_CTRL_TIMEOUT_EN`.
- Defined: when `cnt` saturates in MEAS, the controller ends the pulse immediately. It enters REPORT with `evt_width=2^CNT_W−1`, forces `evt_ok=0`, and clears `c`. After the handshake it goes to WAIT_LOW until `a_s=0`.
- Undefined: `cnt` stays saturated and `c` stays high until `a_s` falls. `evt_ok` is computed normally from the saturated value.

## Test plan
- Reset: hold `rst=1` for 2 cycles with `a=1` → all outputs 0, `busy=0`, and no event after `rst` deasserts, until `a` falls and rises again.
- Defaults with `evt_ready=1`, `a` high for 13 cycles → `c` high for 4 cycles starting 11 edges after e0; `evt_width=13`, `evt_ok=1`, `evt_valid` one cycle.
- `a` high for 9 cycles → `c` stays 0; `evt_width=9`, `evt_ok=0`.
- `evt_ready=0`; 13-cycle pulse, then a 5-cycle pulse during REPORT → `evt_width` stays 13 and `ovf=1`. Then `evt_ready=1` → one event only. Then `cfg_we` in IDLE → `ovf=0`.
- `cfg_we` with `min=3`, `max=5` during MEAS → ignored. The same write in IDLE, then a 5-cycle pulse → `c` high 3 cycles, `evt_ok=1`; a 6-cycle pulse → `evt_ok=0`.
- `CNT_W=4`, `a` high for 20 cycles:
  - With macro: `c` falls at saturation, `evt_width=15`, `evt_ok=0`, and `busy` stays 1 until `a` is low.
  - Without macro: `c` high until `a` falls, `evt_width=15`.
